// File: rtl/rom_arbiter_pkg.sv
// rtl/rom_arbiter_pkg.sv - shared constants and helpers for the ROM read-port arbiter
package rom_arbiter_pkg;

    // Cycles from an accepted grant to the matching rvalid/rdata.
    localparam int ROM_RD_LATENCY = 1;

    // Width of a binary index over n requesters (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// rtl/rom_arbiter_rr_pick.sv - combinational round-robin priority picker
import rom_arbiter_pkg::*;

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      w,
    output logic               any
);

    int idx;

    // Scan req starting at ptr, wrapping; the first set bit wins.
    always_comb begin
        gnt = '0;
        w   = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[idx]) begin
                any      = 1'b1;
                w        = PW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing one synchronous ROM read port
import rom_arbiter_pkg::*;

module rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          idle,
    output logic [ADDR_WIDTH-1:0]         rom_raddr,
    input  logic [DATA_WIDTH-1:0]         rom_q
);

    localparam int PW = ptr_width(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      w;
    logic               any;
    logic [NUM_REQ-1:0] rvalid_r;
    logic               idle_r;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .w   (w),
        .any (any)
    );

    // Address mux: the one-hot grant selects the winner's address, zero when idle.
    always_comb begin
        rom_raddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                rom_raddr = rom_raddr | addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Pointer advances past the winner; response tag and idle flag track the issued read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            rvalid_r <= '0;
            idle_r   <= 1'b1;
        end else begin
            if (any) begin
                ptr <= (w == PW'(NUM_REQ - 1)) ? '0 : w + PW'(1);
            end
            rvalid_r <= gnt;
            idle_r   <= !any;
        end
    end

    assign rvalid = rvalid_r;
    assign idle   = idle_r;
    assign rdata  = rom_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter with a behavioural ROM
module tb_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic [DW-1:0] rdata;
    logic          idle;
    logic [AW-1:0] rom_raddr;
    logic [DW-1:0] rom_q;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks;
    int failures;

    // Reference model state
    int           mptr;
    logic [N-1:0] exp_rv;
    logic         exp_idle;
    logic [7:0]   exp_rd;

    rom_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .addr      (addr),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .idle      (idle),
        .rom_raddr (rom_raddr),
        .rom_q     (rom_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a] = 8'(a) ^ 8'hA5;
        end
    end

    always @(posedge clk) rom_q <= mem[rom_raddr];

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt(input int w);
        return (w >= 0) ? N'(1 << w) : '0;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int w);
        logic [AW-1:0] a;
        a = '0;
        if (w >= 0) a = addr[w*AW +: AW];
        return a;
    endfunction

    // Apply model for the current inputs, then step one clock edge.
    task automatic advance(output int w);
        logic [AW-1:0] a;
        w = pick(req, mptr);
        if (w >= 0) begin
            a        = addr[w*AW +: AW];
            mptr     = (w + 1) % N;
            exp_rv   = N'(1 << w);
            exp_idle = 1'b0;
            exp_rd   = a[7:0] ^ 8'hA5;
        end else begin
            exp_rv   = '0;
            exp_idle = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        addr  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mptr     = 0;
        exp_rv   = '0;
        exp_idle = 1'b1;
    endtask

    task automatic test_reset();
        req   = '0;
        addr  = '0;
        rst_n = 1'b0;
        #1;
        checks++; if (rvalid !== 4'b0) begin failures++; $display("FAIL reset_rvalid_async got=%b exp=0000", rvalid); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle_async got=%b exp=1", idle); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mptr  = 0;
        #1;
        checks++; if (rvalid !== 4'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
        checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (rom_raddr !== 9'h0) begin failures++; $display("FAIL reset_raddr got=%h exp=000", rom_raddr); end
    endtask

    task automatic test_single();
        int w;
        req = 4'b0010;
        addr = '0;
        addr[1*AW +: AW] = 9'h013;
        #1;
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL single_gnt got=%b exp=0010", gnt); end
        checks++; if (rom_raddr !== 9'h013) begin failures++; $display("FAIL single_raddr got=%h exp=013", rom_raddr); end
        advance(w);
        req = '0;
        checks++; if (rvalid !== 4'b0010) begin failures++; $display("FAIL single_rvalid got=%b exp=0010", rvalid); end
        checks++; if (rdata !== 8'hB6) begin failures++; $display("FAIL single_rdata got=%h exp=b6", rdata); end
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", idle); end
        advance(w);
    endtask

    task automatic test_contention();
        int w;
        logic [7:0] rd_tab [4];
        rd_tab[0] = 8'hA5; rd_tab[1] = 8'hA4; rd_tab[2] = 8'hA7; rd_tab[3] = 8'hA6;
        do_reset();
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(i);
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (gnt !== N'(1 << (c % 4))) begin failures++; $display("FAIL contention_gnt c=%0d got=%b exp=%b", c, gnt, N'(1 << (c % 4))); end
            advance(w);
            checks++; if (rvalid !== N'(1 << (c % 4))) begin failures++; $display("FAIL contention_rvalid c=%0d got=%b exp=%b", c, rvalid, N'(1 << (c % 4))); end
            checks++; if (rdata !== rd_tab[c % 4]) begin failures++; $display("FAIL contention_rdata c=%0d got=%h exp=%h", c, rdata, rd_tab[c % 4]); end
        end
        req = '0;
        advance(w);
    endtask

    task automatic test_pointer_fairness();
        int w;
        req = 4'b1000;
        addr[3*AW +: AW] = 9'h1F0;
        #1;
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL fair_gnt3 got=%b exp=1000", gnt); end
        advance(w);
        req = 4'b1001;
        addr[0] = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL fair_wrap_gnt0 got=%b exp=0001", gnt); end
        advance(w);
        req = 4'b1000;
        #1;
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL fair_then_gnt3 got=%b exp=1000", gnt); end
        advance(w);
        checks++; if (rvalid !== 4'b1000 || rdata !== 8'h55) begin failures++; $display("FAIL fair_rdata got=%b/%h exp=1000/55", rvalid, rdata); end
        req = '0;
        advance(w);
    endtask

    task automatic test_reset_mid();
        int w;
        req = 4'b0100;
        addr[2*AW +: AW] = 9'h0AA;
        #1;
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL midrst_gnt got=%b exp=0100", gnt); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (rvalid !== 4'b0000) begin failures++; $display("FAIL midrst_rvalid got=%b exp=0000", rvalid); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", idle); end
        rst_n = 1'b1;
        mptr  = 0;
        req   = 4'b0101;
        addr[0*AW +: AW] = 9'h003;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL midrst_ptr0_gnt got=%b exp=0001", gnt); end
        advance(w);
        checks++; if (rvalid !== 4'b0001 || rdata !== 8'hA6) begin failures++; $display("FAIL midrst_resp got=%b/%h exp=0001/a6", rvalid, rdata); end
        req = '0;
        advance(w);
    endtask

    task automatic test_idle_gap();
        int w;
        req = 4'b0001;
        addr[0*AW +: AW] = 9'h005;
        advance(w);
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL gap_idle0 got=%b exp=0", idle); end
        req = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (gnt !== 4'b0 || rom_raddr !== 9'h0) begin failures++; $display("FAIL gap_nognt got=%b/%h exp=0000/000", gnt, rom_raddr); end
            advance(w);
            checks++; if (idle !== 1'b1) begin failures++; $display("FAIL gap_idle1 c=%0d got=%b exp=1", c, idle); end
            checks++; if (dut.ptr !== 2'd1) begin failures++; $display("FAIL gap_ptr c=%0d got=%0d exp=1", c, dut.ptr); end
        end
        req = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL gap_rereq_gnt got=%b exp=0001", gnt); end
        advance(w);
        req = '0;
        advance(w);
    endtask

    task automatic test_random();
        int w;
        int wt [N];
        logic [N-1:0] pending;
        pending = '0;
        for (int i = 0; i < N; i++) wt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    addr[i*AW +: AW] = AW'($urandom);
                    wt[i] = 0;
                end
            end
            req = pending;
            #1;
            w = pick(req, mptr);
            checks++; if (gnt !== exp_gnt(w)) begin failures++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt(w)); end
            checks++; if (rom_raddr !== exp_addr(w)) begin failures++; $display("FAIL rand_raddr c=%0d got=%h exp=%h", c, rom_raddr, exp_addr(w)); end
            advance(w);
            checks++; if (rvalid !== exp_rv || idle !== exp_idle) begin failures++; $display("FAIL rand_regs c=%0d got=%b/%b exp=%b/%b", c, rvalid, idle, exp_rv, exp_idle); end
            if (exp_rv != '0) begin
                checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, rdata, exp_rd); end
            end
            for (int i = 0; i < N; i++) begin
                if (pending[i]) begin
                    if (i == w) begin
                        checks++; if (wt[i] > N - 1) begin failures++; $display("FAIL rand_fairness req=%0d waited=%0d max=%0d", i, wt[i], N - 1); end
                        pending[i] = 1'b0;
                    end else begin
                        wt[i]++;
                    end
                end
            end
        end
        req = '0;
        advance(w);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mptr     = 0;
        exp_rv   = '0;
        exp_idle = 1'b1;
        exp_rd   = '0;
        rst_n    = 1'b1;
        req      = '0;
        addr     = '0;
        #2;
        test_reset();
        test_single();
        test_contention();
        test_pointer_fairness();
        test_reset_mid();
        test_idle_gap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
